// File: rtl/pb_uart_mon_pkg.sv
// Shared types and defaults for the UART receive monitor.
// Holds the receiver state encoding and default sizing constants.
package pb_uart_mon_pkg;

    localparam int unsigned DefClkPerBit = 8;
    localparam int unsigned DefFifoDepth = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO, common_cells fifo_v3 compatible subset.
// Storage is reset so the head reads as zero while empty after reset.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_DEPTH-1:0] wr_ptr_q;
    logic [ADDR_DEPTH-1:0] rd_ptr_q;
    logic [ADDR_DEPTH:0]   cnt_q;
    logic                  bypass;
    logic                  wr_en;
    logic                  rd_en;

    assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];

    assign bypass = FALL_THROUGH && empty_o && push_i && pop_i;
    assign wr_en  = push_i && !full_o && !bypass;
    assign rd_en  = pop_i && !empty_o;

    assign data_o = (FALL_THROUGH && empty_o) ? data_i : mem_q[rd_ptr_q];

    // Pointer, occupancy and storage update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + ADDR_DEPTH'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + ADDR_DEPTH'(1);
            end
            if (wr_en && !rd_en) begin
                cnt_q <= cnt_q + (ADDR_DEPTH+1)'(1);
            end else if (!wr_en && rd_en) begin
                cnt_q <= cnt_q - (ADDR_DEPTH+1)'(1);
            end
        end
    end

endmodule

// File: rtl/pb_uart_rx_monitor.sv
// UART receive monitor: samples a serial line, buffers bytes in a FIFO.
// Flags framing errors, FIFO overflow and end-of-line bytes at the head.
module pb_uart_rx_monitor
    import pb_uart_mon_pkg::*;
#(
    parameter int unsigned ClkPerBit = DefClkPerBit,
    parameter int unsigned FifoDepth = DefFifoDepth
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       uart_rx_i,
    output logic [7:0]                 byte_o,
    output logic                       byte_valid_o,
    input  logic                       byte_ready_i,
    output logic                       eol_o,
    output logic                       frame_err_o,
    output logic                       overflow_o,
    output logic [$clog2(FifoDepth):0] fill_o
);

    localparam int unsigned CntW = $clog2(ClkPerBit);
    localparam int unsigned AddrW = $clog2(FifoDepth);
    localparam logic [CntW-1:0] HalfLoad = CntW'(ClkPerBit / 2 - 1);
    localparam logic [CntW-1:0] BitLoad = CntW'(ClkPerBit - 1);

    logic [1:0]      sync_q;
    logic            line;
    rx_state_e       state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shreg_q;
    logic            tick;
    logic            push;
    logic            push_ok;
    logic            pop;
    logic            full;
    logic            empty;
    logic [AddrW-1:0] usage;

    assign line = sync_q[1];
    assign tick = (cnt_q == '0);

    // Two-flop synchronizer; idles high so reset never looks like a start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rx_i};
        end
    end

    // Receiver FSM with bit timer, bit index, shifter and error pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!line) begin
                        state_q <= START;
                        cnt_q   <= HalfLoad;
                    end
                end
                START: begin
                    if (!tick) begin
                        cnt_q <= cnt_q - CntW'(1);
                    end else if (!line) begin
                        state_q   <= DATA;
                        cnt_q     <= BitLoad;
                        bit_idx_q <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    if (!tick) begin
                        cnt_q <= cnt_q - CntW'(1);
                    end else begin
                        shreg_q <= {line, shreg_q[7:1]};
                        cnt_q   <= BitLoad;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (!tick) begin
                        cnt_q <= cnt_q - CntW'(1);
                    end else if (line) begin
                        state_q <= IDLE;
                    end else begin
                        frame_err_o <= 1'b1;
                        state_q     <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (line) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign push    = (state_q == STOP) && tick && line;
    assign push_ok = push && !full;
    assign pop     = byte_valid_o && byte_ready_i;

    // Sticky overflow: a good frame arrived with no room to keep it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
        end else if (push && full) begin
            overflow_o <= 1'b1;
        end
    end

    fifo_v3 #(
        .FALL_THROUGH(1'b0),
        .DATA_WIDTH  (8),
        .DEPTH       (FifoDepth)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (~rst_i),
        .flush_i(1'b0),
        .full_o (full),
        .empty_o(empty),
        .usage_o(usage),
        .data_i (shreg_q),
        .push_i (push_ok),
        .data_o (byte_o),
        .pop_i  (pop)
    );

    assign byte_valid_o = !empty;
    assign eol_o        = byte_valid_o && (byte_o == 8'h0A);
    assign fill_o       = {full, usage};

endmodule

// File: tb/tb_pb_uart_rx_monitor.sv
// Directed bench for the UART receive monitor.
// Expected bytes go into a queue; a monitor pops and compares on each handshake.
module tb_pb_uart_rx_monitor;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       eol;
    logic       frame_err;
    logic       overflow;
    logic [4:0] fill;

    int n_chk = 0;
    int n_fail = 0;
    int ferr_cnt = 0;
    logic [7:0] expq[$];

    pb_uart_rx_monitor #(
        .ClkPerBit(8),
        .FifoDepth(16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .uart_rx_i   (rx),
        .byte_o      (byte_out),
        .byte_valid_o(byte_valid),
        .byte_ready_i(byte_ready),
        .eol_o       (eol),
        .frame_err_o (frame_err),
        .overflow_o  (overflow),
        .fill_o      (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val,
                              input int stop_bits);
        @(posedge clk);
        #1 rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (8) @(posedge clk);
            #1 rx = d[i];
        end
        repeat (8) @(posedge clk);
        #1 rx = stop_val;
        repeat (8 * stop_bits) @(posedge clk);
        #1 rx = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        @(posedge clk);
        #1 byte_ready = 1'b1;
        while ((expq.size() != 0 || byte_valid) && n < max_cyc) begin
            @(posedge clk);
            #2;
            n++;
        end
        byte_ready = 1'b0;
        check("drain_queue_left", expq.size(), 0);
        check("drain_valid", byte_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, byte_valid, 0);
        check({tag, "_eol"}, eol, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_fill"}, fill, 0);
        check({tag, "_byte"}, byte_out, 0);
    endtask

    // Scoreboard monitor: each accepted byte must match the queue head.
    always @(negedge clk) begin
        if (!rst && byte_valid && byte_ready) begin
            if (expq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pop: got %0h expected none",
                         byte_out);
            end else begin
                logic [7:0] e;
                e = expq.pop_front();
                check("pop_byte", byte_out, e);
                check("pop_eol", eol, (e == 8'h0A));
            end
        end
    end

    // Count cycles with the framing-error pulse high.
    always @(negedge clk) begin
        if (!rst && frame_err) ferr_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        byte_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        // 0x55 with exact one-cycle latency after the stop sample
        expq.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1, 1);
            begin
                repeat (79) @(posedge clk);
                #2 check("lat_pre_valid", byte_valid, 0);
                @(posedge clk);
                #2;
                check("lat_valid", byte_valid, 1);
                check("lat_byte", byte_out, 8'h55);
                check("lat_fill", fill, 1);
                check("lat_ferr", ferr_cnt, 0);
            end
        join
        drain(20);

        // end-of-line flag follows the head byte
        expq.push_back(8'h0A);
        send_frame(8'h0A, 1'b1, 1);
        @(negedge clk);
        check("eol_head", eol, 1);
        check("eol_byte", byte_out, 8'h0A);
        drain(20);
        @(negedge clk);
        check("eol_after_pop", eol, 0);

        // short low glitch, then a frame right behind it
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check("glitch_fill", fill, 0);
        check("glitch_valid", byte_valid, 0);
        check("glitch_ferr", ferr_cnt, 0);
        expq.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, 1);
        drain(20);

        // stop bit held low for 20 bit times
        send_frame(8'hA3, 1'b0, 20);
        #2;
        check("ferr_count", ferr_cnt, 1);
        check("ferr_fill", fill, 0);
        check("ferr_valid", byte_valid, 0);
        expq.push_back(8'h31);
        send_frame(8'h31, 1'b1, 1);
        @(negedge clk);
        check("after_ferr_byte", byte_out, 8'h31);
        drain(20);

        // fill to capacity, overflow on the 17th frame
        for (int i = 0; i < 17; i++) begin
            if (i < 16) expq.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1);
            if (i == 15) begin
                @(negedge clk);
                check("full_fill16", fill, 16);
                check("full_no_ovf", overflow, 0);
            end
        end
        @(negedge clk);
        check("ovf_fill", fill, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_head", byte_out, 8'h00);
        drain(100);
        @(negedge clk);
        check("ovf_sticky", overflow, 1);
        check("ovf_drained_fill", fill, 0);

        // reset in the middle of data bit 4
        fork
            send_frame(8'h7E, 1'b1, 1);
            begin
                repeat (44) @(posedge clk);
                #2 rst = 1'b1;
                @(negedge clk);
                check_reset_outputs("midrst");
            end
        join
        @(negedge clk);
        check_reset_outputs("midrst_hold");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ovf", overflow, 0);
        check("post_rst_fill", fill, 0);
        expq.push_back(8'h42);
        send_frame(8'h42, 1'b1, 1);
        @(negedge clk);
        check("post_rst_byte", byte_out, 8'h42);
        check("post_rst_fill1", fill, 1);
        drain(20);
        check("final_ferr", ferr_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
